alu_div_sequencer: RTL and testbench

- Multi-cycle controller that executes RV32M DIV/DIVU/REM/REMU by sequencing the shared single-cycle ALU through 32 restoring-division iterations.
- Each iteration drives the ALU with an unsigned subtract and uses its less-than flag to decide whether to restore.
- Sits beside the execute stage. Competes for the ALU through a req/gnt handshake owned by the datapath arbiter, and returns one registered result per accepted command.

---
 rtl/alu_div_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_div_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_sequencer.sv
// Multi-cycle RV32M divide/remainder controller. It borrows the shared ALU for XLEN
// restoring-division steps, one unsigned subtract per granted cycle.
module alu_div_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_alu_req,
  input  logic            i_alu_gnt,
  output logic [2:0]      o_alu_opsel,
  output logic            o_alu_sub,
  output logic            o_alu_unsigned,
  output logic            o_alu_arith,
  output logic [XLEN-1:0] o_alu_op1,
  output logic [XLEN-1:0] o_alu_op2,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_alu_slt
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      op_q;
  logic            dvd_sign_q, dvs_sign_q, special_q, valid_q;

  logic            signed_op, dvd_neg, dvs_neg, div_zero, overflow;
  logic            in_run, qbit, neg_quo, neg_rem;
  logic [XLEN-1:0] dvd_mag, dvs_mag, shifted, quo_res, rem_res;

  always_comb begin
    signed_op = ~i_op[0];
    dvd_neg   = signed_op & i_dividend[XLEN-1];
    dvs_neg   = signed_op & i_divisor[XLEN-1];
    dvd_mag   = dvd_neg ? ('0 - i_dividend) : i_dividend;
    dvs_mag   = dvs_neg ? ('0 - i_divisor) : i_divisor;
    div_zero  = (i_divisor == '0);
    overflow  = signed_op & (i_dividend == MinInt) & (i_divisor == '1);

    in_run    = (state_q == StRun);
    shifted   = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    // A set rem MSB means the shifted value really exceeds 2^XLEN, so it always subtracts.
    qbit      = rem_q[XLEN-1] | ~i_alu_slt;

    // Sign fix-ups apply only to signed ops; special-case results are already final.
    neg_quo   = ~op_q[0] & (dvd_sign_q ^ dvs_sign_q) & ~special_q;
    neg_rem   = ~op_q[0] & dvd_sign_q & ~special_q;
    quo_res   = neg_quo ? ('0 - quo_q) : quo_q;
    rem_res   = neg_rem ? ('0 - rem_q) : rem_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      dvd_sign_q <= 1'b0;
      dvs_sign_q <= 1'b0;
      special_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            op_q       <= i_op;
            dvd_sign_q <= i_dividend[XLEN-1];
            dvs_sign_q <= i_divisor[XLEN-1];
            dvsr_q     <= dvs_mag;
            cnt_q      <= '0;
            if (div_zero) begin
              special_q <= 1'b1;
              quo_q     <= '1;
              rem_q     <= i_dividend;
              state_q   <= StDone;
            end else if (overflow) begin
              special_q <= 1'b1;
              quo_q     <= MinInt;
              rem_q     <= '0;
              state_q   <= StDone;
            end else begin
              special_q <= 1'b0;
              quo_q     <= dvd_mag;
              rem_q     <= '0;
              state_q   <= StRun;
            end
          end
        end
        StRun: begin
          if (i_alu_gnt) begin
            rem_q <= qbit ? i_alu_result : shifted;
            quo_q <= {quo_q[XLEN-2:0], qbit};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          valid_q  <= 1'b1;
          result_q <= op_q[1] ? rem_res : quo_res;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy         = (state_q != StIdle);
  assign o_valid        = valid_q;
  assign o_result       = result_q;
  assign o_alu_req      = in_run;
  assign o_alu_opsel    = 3'b000;
  assign o_alu_sub      = in_run;
  assign o_alu_unsigned = in_run;
  assign o_alu_arith    = 1'b0;
  assign o_alu_op1      = in_run ? shifted : '0;
  assign o_alu_op2      = in_run ? dvsr_q : '0;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Scoreboard bench for alu_div_sequencer: plain-arithmetic reference results and a
// grant-counting timing model, checked by an independent negedge monitor.
module tb_alu_div_sequencer;

  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, gnt = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] dvd = '0, dvs = '0;
  logic        busy, valid, alu_req, alu_sub, alu_uns, alu_arith, alu_slt;
  logic [2:0]  alu_opsel;
  logic [31:0] result, alu_op1, alu_op2, alu_result;

  alu_div_sequencer #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_dividend(dvd), .i_divisor(dvs), .o_busy(busy), .o_valid(valid),
    .o_result(result), .o_alu_req(alu_req), .i_alu_gnt(gnt), .o_alu_opsel(alu_opsel),
    .o_alu_sub(alu_sub), .o_alu_unsigned(alu_uns), .o_alu_arith(alu_arith),
    .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .i_alu_result(alu_result),
    .i_alu_slt(alu_slt)
  );

  // Shared single-cycle ALU as seen by the sequencer.
  always_comb begin
    alu_result = (alu_opsel == 3'b000 && alu_sub) ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
    alu_slt    = alu_uns ? (alu_op1 < alu_op2) : ($signed(alu_op1) < $signed(alu_op2));
  end

  always #5 clk = ~clk;

  int          n_cmp = 0, n_fail = 0;
  logic [31:0] sb_q[$];
  int          edge_cnt = 0, exp_valid_edge = -1, m_grants = 0, gnt_mode = 0;
  bit          m_busy = 1'b0, m_run = 1'b0, v_pend = 1'b0;
  logic [31:0] exp_op2 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, b);
    int  sa, sb;
    bit  ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      OpDiv:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      OpDivu:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRem:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic [1:0] o, input logic [31:0] x);
    return (!o[0] && x[31]) ? 32'd0 - x : x;
  endfunction

  // Timing model: RUN lasts until 32 granted edges, then one DONE edge before valid.
  initial begin
    bit was_busy;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst_n) begin
        was_busy = m_busy;
        if (m_run && gnt) begin
          m_grants++;
          if (m_grants == 32) begin
            m_run          = 1'b0;
            exp_valid_edge = edge_cnt + 1;
          end
        end
        if (m_busy && !m_run && edge_cnt == exp_valid_edge) m_busy = 1'b0;
        if (start && !was_busy) begin
          sb_q.push_back(ref_model(op, dvd, dvs));
          v_pend  = 1'b1;
          m_busy  = 1'b1;
          exp_op2 = mag(op, dvs);
          if (is_special(op, dvd, dvs)) begin
            exp_valid_edge = edge_cnt + 1;
          end else begin
            exp_valid_edge = -1;
            m_run          = 1'b1;
            m_grants       = 0;
          end
        end
      end
    end
  end

  // Monitor: compares every cycle, pops the scoreboard on each result strobe.
  initial begin
    bit          exp_v, prev_req, prev_gnt;
    logic [31:0] prev_op1, prev_op2, r;
    prev_req = 1'b0;
    prev_gnt = 1'b0;
    prev_op1 = '0;
    prev_op2 = '0;
    forever begin
      @(negedge clk);
      exp_v = v_pend && !m_run && (edge_cnt == exp_valid_edge);
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("alu_req", {31'd0, alu_req}, {31'd0, m_run});
      check("valid", {31'd0, valid}, {31'd0, exp_v});
      if (valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          r = sb_q.pop_front();
          check("result", result, r);
        end
      end
      if (exp_v) v_pend = 1'b0;
      if (alu_req) begin
        check("alu_ctrl", {26'd0, alu_opsel, alu_sub, alu_uns, alu_arith}, 32'b110);
        check("alu_op2", alu_op2, exp_op2);
      end else begin
        check("alu_idle", {26'd0, alu_opsel, alu_sub, alu_uns, alu_arith} | alu_op1 | alu_op2,
              32'd0);
      end
      if (prev_req && !prev_gnt && alu_req) begin
        check("op1_hold", alu_op1, prev_op1);
        check("op2_hold", alu_op2, prev_op2);
      end
      prev_req = alu_req;
      prev_gnt = gnt;
      prev_op1 = alu_op1;
      prev_op2 = alu_op2;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      gnt = (gnt_mode != 0) ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (m_busy && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (m_busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    op    = o;
    dvd   = a;
    dvs   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom_range(3, 0));
    dvd   = $urandom;
    dvs   = $urandom;
  endtask

  task automatic reset_mid(input int iters);
    gnt_mode = 0;
    issue(OpDivu, 32'd1000, 32'd3);
    repeat (iters) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    v_pend = 1'b0;
    m_busy = 1'b0;
    m_run  = 1'b0;
    #1;
    check("rst_outs", {29'd0, busy, valid, alu_req}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_op1", alu_op1, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a, b;
    int          sel;
    #1 rst_n = 1'b0;
    #2;
    check("reset_outs", {29'd0, busy, valid, alu_req}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    gnt_mode = 0;
    issue(OpDivu, 32'd100, 32'd7);
    issue(OpRemu, 32'd100, 32'd7);
    issue(OpDiv, 32'hFFFF_FF9C, 32'd7);
    issue(OpRem, 32'hFFFF_FF9C, 32'd7);
    issue(OpRem, 32'd100, 32'hFFFF_FFF9);
    issue(OpDivu, 32'd5, 32'd0);
    issue(OpRem, 32'h8000_0000, 32'd0);
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OpRem, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OpDivu, 32'hFFFF_FFFF, 32'h8000_0001);
    issue(OpRemu, 32'hFFFF_FFFF, 32'h8000_0001);

    // A start during RUN must be dropped.
    issue(OpDivu, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    op    = OpDiv;
    dvd   = 32'd7;
    dvs   = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    gnt_mode = 1;
    issue(OpDivu, 32'd1000, 32'd3);

    reset_mid(10);
    issue(OpDivu, 32'd9, 32'd3);

    for (int i = 0; i < 30; i++) begin
      gnt_mode = int'($urandom_range(1, 0));
      sel      = int'($urandom_range(5, 0));
      a        = $urandom;
      b        = $urandom;
      case (sel)
        0: b = b >> $urandom_range(31, 0);
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = a >> 20; b = (b >> 28) | 32'd1; end
        4: b = 32'd0 - ((b >> 24) | 32'd1);
        default: ;
      endcase
      issue(2'($urandom_range(3, 0)), a, b);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
